// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl
//   Turns a bouncy, active-low board push-button into the mode control for
//   streamed_led. The raw key is synchronised and debounced; a short press
//   toggles mode on release, a long press toggles an auto-cycle function that
//   flips mode every AUTO_CYC clocks.
//
// Ports
//   clk      in   system clock, rising edge
//   rstn     in   asynchronous active-low reset
//   key_n    in   raw button, asynchronous, 0 = pressed
//   mode     out  registered mode to streamed_led
//   mode_chg out  one-cycle pulse in the cycle mode changes value
//   auto_en  out  registered auto-cycle enable
module key_mode_ctrl #(
  parameter int DEBOUNCE_CYC = 200000,
  parameter int LONG_CYC     = 20000000,
  parameter int AUTO_CYC     = 100000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_n,
  output logic mode,
  output logic mode_chg,
  output logic auto_en
);

  // One counter width large enough for every timing parameter.
  localparam int MAX_DL  = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
  localparam int MAX_CYC = (MAX_DL > AUTO_CYC) ? MAX_DL : AUTO_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DEB_V   = CW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0] LONG_M1 = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] AUTO_M1 = CW'(AUTO_CYC - 1);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_PRESS_FILT = 3'd1;
  localparam logic [2:0] ST_DOWN       = 3'd2;
  localparam logic [2:0] ST_HELD       = 3'd3;
  localparam logic [2:0] ST_REL_FILT   = 3'd4;

  logic          sync_q, sync_d;
  logic          key_s_q, key_s_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          short_q, short_d;
  logic          mode_q, mode_d;
  logic          mode_chg_q, mode_chg_d;
  logic          auto_en_q, auto_en_d;
  logic [CW-1:0] auto_cnt_q, auto_cnt_d;

  logic          man_tgl;
  logic          auto_tgl;
  logic          auto_tick;
  logic          any_tgl;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] hold_inc;

  assign mode     = mode_q;
  assign mode_chg = mode_chg_q;
  assign auto_en  = auto_en_q;

  // Two-flop synchroniser; both flops reset to the released level.
  always_comb begin
    sync_d  = key_n;
    key_s_d = sync_q;
  end

  // Press/release state machine. cnt counts consecutive stable samples of
  // the new level; the transition fires on the sample that makes it
  // DEBOUNCE_CYC. hold_cnt only advances while in DOWN, so a bounce during
  // release filtering resumes the long-press timing where it left off.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    short_d  = short_q;
    man_tgl  = 1'b0;
    auto_tgl = 1'b0;
    cnt_inc  = cnt_q + ONE;
    hold_inc = hold_q + ONE;
    case (state_q)
      ST_IDLE: begin
        if (!key_s_q) begin
          state_d = ST_PRESS_FILT;
          cnt_d   = ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_PRESS_FILT: begin
        if (key_s_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= DEB_V) begin
          state_d = ST_DOWN;
          cnt_d   = '0;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DOWN: begin
        if (key_s_q) begin
          state_d = ST_REL_FILT;
          cnt_d   = ONE;
          short_d = 1'b1;
        end else begin
          hold_d = hold_inc;
          if (hold_inc >= LONG_M1) begin
            state_d  = ST_HELD;
            auto_tgl = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (key_s_q) begin
          state_d = ST_REL_FILT;
          cnt_d   = ONE;
          short_d = 1'b0;
        end
      end
      ST_REL_FILT: begin
        if (!key_s_q) begin
          state_d = short_q ? ST_DOWN : ST_HELD;
          cnt_d   = '0;
        end else if (cnt_inc >= DEB_V) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          man_tgl = short_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Mode and auto-cycle. A manual toggle colliding with an auto tick still
  // gives a single toggle; any toggle restarts the auto period.
  always_comb begin
    auto_tick  = auto_en_q && (auto_cnt_q == AUTO_M1);
    any_tgl    = man_tgl || auto_tick;
    mode_d     = mode_q ^ any_tgl;
    mode_chg_d = any_tgl;
    auto_en_d  = auto_en_q ^ auto_tgl;
    if (!auto_en_q || auto_tgl || any_tgl) begin
      auto_cnt_d = '0;
    end else begin
      auto_cnt_d = auto_cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q     <= 1'b1;
      key_s_q    <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      short_q    <= 1'b0;
      mode_q     <= 1'b0;
      mode_chg_q <= 1'b0;
      auto_en_q  <= 1'b0;
      auto_cnt_q <= '0;
    end else begin
      sync_q     <= sync_d;
      key_s_q    <= key_s_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      short_q    <= short_d;
      mode_q     <= mode_d;
      mode_chg_q <= mode_chg_d;
      auto_en_q  <= auto_en_d;
      auto_cnt_q <= auto_cnt_d;
    end
  end

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Testbench for key_mode_ctrl with small timing parameters.
module tb_key_mode_ctrl;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int AUTO = 10;
  localparam int NEED_RUN = (DEB < 2) ? 2 : DEB;

  logic clk = 1'b0;
  logic rstn;
  logic key_n;
  logic mode;
  logic mode_chg;
  logic auto_en;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural reference: key level seen after synchronisation, a
  // debounced pressed flag with a run length of opposing samples, a
  // long-press timer and a free-running auto period.
  bit m_s1, m_ks, m_pressed, m_long, m_mode, m_chg, m_auto;
  int m_run, m_hold, m_acnt;

  typedef struct {
    logic rst_v;
    logic key_v;
    int   cycles;
    logic exp_mode;
    logic exp_auto;
    int   exp_pulses;
  } seg_t;

  seg_t tbl[11];

  key_mode_ctrl #(
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC(LONG),
    .AUTO_CYC(AUTO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .key_n(key_n),
    .mode(mode),
    .mode_chg(mode_chg),
    .auto_en(auto_en)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_s1 = 1'b1; m_ks = 1'b1; m_pressed = 1'b0; m_long = 1'b0;
    m_mode = 1'b0; m_chg = 1'b0; m_auto = 1'b0;
    m_run = 0; m_hold = 0; m_acnt = 0;
  endtask

  task automatic modelStep(input bit k);
    bit s, manual, flip_auto, tick, tgl;
    s = m_ks;
    manual = 1'b0;
    flip_auto = 1'b0;
    if (!m_pressed) begin
      if (!s) begin
        m_run++;
        if (m_run >= NEED_RUN) begin
          m_pressed = 1'b1; m_run = 0; m_hold = 0; m_long = 1'b0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (s) begin
        m_run++;
        if (m_run >= NEED_RUN) begin
          m_pressed = 1'b0; m_run = 0;
          manual = !m_long;
          m_long = 1'b0;
        end
      end else if (m_run > 0) begin
        m_run = 0;
      end else if (!m_long) begin
        m_hold++;
        if (m_hold >= LONG - 1) begin
          m_long = 1'b1;
          flip_auto = 1'b1;
        end
      end
    end
    tick = m_auto && (m_acnt == AUTO - 1);
    tgl  = manual || tick;
    if (!m_auto || flip_auto || tgl) m_acnt = 0;
    else m_acnt++;
    m_mode = m_mode ^ tgl;
    m_chg  = tgl;
    m_auto = m_auto ^ flip_auto;
    m_ks = m_s1;
    m_s1 = k;
  endtask

  // Drive one clock of stimulus, advance the model and compare all outputs.
  task automatic applyStimulus(input logic r, input logic k);
    rstn  = r;
    key_n = k;
    if (!r) modelReset();
    @(posedge clk);
    if (r) modelStep(k);
    else modelReset();
    #1;
    checkOutput("model", int'({mode, mode_chg, auto_en}), int'({m_mode, m_chg, m_auto}));
  endtask

  // Main sequence: table segments, hand-timed corner cases, then random.
  initial begin
    int pulses;
    tbl[0]  = '{1'b0, 1'b0,  5, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b1,  5, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b1, 50, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0,  3, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b1, 1'b1, 10, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b1, 1'b0, 10, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b1, 1'b1, 10, 1'b1, 1'b0, 1};
    tbl[7]  = '{1'b1, 1'b0, 40, 1'b0, 1'b1, 1};
    tbl[8]  = '{1'b1, 1'b1, 25, 1'b1, 1'b1, 3};
    tbl[9]  = '{1'b1, 1'b0, 30, 1'b1, 1'b0, 2};
    tbl[10] = '{1'b1, 1'b1, 30, 1'b1, 1'b0, 0};

    rstn  = 1'b0;
    key_n = 1'b1;
    modelReset();
    #1;
    checkOutput("reset mode", int'(mode), 0);
    checkOutput("reset auto_en", int'(auto_en), 0);
    checkOutput("reset mode_chg", int'(mode_chg), 0);

    for (int t = 0; t < 11; t++) begin
      pulses = 0;
      for (int c = 0; c < tbl[t].cycles; c++) begin
        applyStimulus(tbl[t].rst_v, tbl[t].key_v);
        if (mode_chg) pulses++;
      end
      checkOutput($sformatf("seg%0d mode", t), int'(mode), int'(tbl[t].exp_mode));
      checkOutput($sformatf("seg%0d auto_en", t), int'(auto_en), int'(tbl[t].exp_auto));
      checkOutput($sformatf("seg%0d pulses", t), pulses, tbl[t].exp_pulses);
    end

    // Short press: toggle lands 2 sync + 4 filter samples after release.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput($sformatf("short chg[%0d]", i), int'(mode_chg), (i == 5) ? 1 : 0);
    end
    checkOutput("short mode", int'(mode), 0);

    // Collision: long press enables auto (ticks at 34,44,54,64); a short
    // press whose release filter completes on cycle 54 must give one toggle.
    for (int i = 0; i < 69; i++) begin
      applyStimulus(1'b1, ((i < 30) || (i >= 39 && i < 49)) ? 1'b0 : 1'b1);
      checkOutput($sformatf("coll chg[%0d]", i), int'(mode_chg),
                  (i == 34 || i == 44 || i == 54 || i == 64) ? 1 : 0);
      if (i == 23) checkOutput("coll auto before", int'(auto_en), 0);
      if (i == 24) checkOutput("coll auto after", int'(auto_en), 1);
      if (i == 54) checkOutput("coll mode", int'(mode), 1);
    end
    checkOutput("coll end mode", int'(mode), 0);
    checkOutput("coll end auto", int'(auto_en), 1);

    // Reset while HELD with auto on; key stays pressed through release.
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("held auto", int'(auto_en), 1);
    rstn = 1'b0;
    modelReset();
    #1;
    checkOutput("async auto", int'(auto_en), 0);
    checkOutput("async mode", int'(mode), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("post rst auto[%0d]", i), int'(auto_en), (i >= 24) ? 1 : 0);
      checkOutput($sformatf("post rst mode[%0d]", i), int'(mode), 0);
    end
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1);

    // Random key activity with occasional resets, checked every cycle.
    for (int s = 0; s < 200; s++) begin
      int kind, len;
      logic lvl;
      kind = $urandom_range(0, 39);
      lvl  = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        len = $urandom_range(1, 3);
        for (int c = 0; c < len; c++) applyStimulus(1'b0, lvl);
      end else begin
        if (kind < 10) len = $urandom_range(1, 5);
        else if (kind < 30) len = $urandom_range(6, 30);
        else len = $urandom_range(30, 60);
        for (int c = 0; c < len; c++) applyStimulus(1'b1, lvl);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_mode_ctrl.md
Name: key_mode_ctrl

Overview:
- Upstream control stage for streamed_led; drives its mode input from a board push-button.
- Synchronises and debounces an active-low key.
- Short press toggles mode; long press toggles an auto-cycle function that flips mode every AUTO_CYC clocks, matching the timed mode switching used in bring-up.
- Runs on the 10 MHz system clock.

Parameters:
- DEBOUNCE_CYC, 200000: consecutive stable synchronised samples needed to accept a key level change (20 ms).
- LONG_CYC, 20000000: confirmed-press duration that counts as a long press (2 s).
- AUTO_CYC, 100000000: clocks between automatic mode toggles when auto_en=1 (10 s).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- key_n  input  1  raw button, asynchronous, 0 = pressed.
- mode  output  1  mode to streamed_led; registered.
- mode_chg  output  1  one-cycle pulse in the cycle mode changes value.
- auto_en  output  1  auto-cycle enabled; registered.

Behaviour:
- Reset (async, rstn=0):
  - mode=0, mode_chg=0, auto_en=0.
  - Synchroniser flops preset to 1 (released).
  - FSM=IDLE; all counters 0.
- Synchroniser: two flops on key_n give key_s, 2-cycle latency. All logic below uses key_s only.
- Counter widths are sized to hold the largest parameter value. Parameters must satisfy DEBOUNCE_CYC ≥ 1 and LONG_CYC > DEBOUNCE_CYC.
- FSM states: IDLE, PRESS_FILT, DOWN, HELD, REL_FILT.
  - IDLE: key_s=0 → PRESS_FILT with cnt=1; otherwise stay with cnt=0.
  - PRESS_FILT: key_s=0 → cnt+1. When cnt reaches DEBOUNCE_CYC → DOWN with hold_cnt=0. key_s=1 at any point → IDLE with cnt=0 (glitch rejected, no output change).
  - DOWN: hold_cnt increments each cycle.
    - hold_cnt reaches LONG_CYC-1 → HELD; auto_en toggles on that edge.
    - key_s=1 before that → REL_FILT with cnt=1 and short_flag=1.
  - HELD: key_s=1 → REL_FILT with cnt=1 and short_flag=0.
  - REL_FILT: key_s=1 → cnt+1.
    - key_s=0 before cnt reaches DEBOUNCE_CYC → return to DOWN if short_flag=1 (hold_cnt keeps counting), else HELD.
    - cnt reaches DEBOUNCE_CYC → IDLE. If short_flag=1, mode toggles and mode_chg=1 on that same edge.
- Short-press action occurs on release, never on press, so a long press never toggles mode.
- Auto-cycle:
  - While auto_en=1, auto_cnt increments each cycle.
  - At auto_cnt=AUTO_CYC-1: mode toggles, mode_chg=1, auto_cnt→0.
  - auto_cnt is forced to 0 while auto_en=0, on the cycle auto_en toggles, and on any manual toggle.
  - Turning auto_en off leaves mode at its current value.
- Simultaneous events: a manual toggle and an auto tick in the same cycle produce exactly one toggle and one mode_chg pulse; auto_cnt→0.
- mode_chg is high for exactly one cycle per mode change and never otherwise.
- Reset asserted mid-press or mid-filter: everything returns to reset values immediately. After rstn releases with the key still held, a fresh PRESS_FILT sequence is required before any action.

Test Plan (sim parameters DEBOUNCE_CYC=4, LONG_CYC=20, AUTO_CYC=10):
- Reset: hold rstn=0 with key_n toggling → mode=0, auto_en=0, mode_chg=0 throughout. After release with key_n=1 for 50 cycles → no change.
- Glitch: key_n=0 for 3 cycles, then 1 → FSM returns to IDLE; mode stays 0; no mode_chg pulse.
- Short press: key_n=0 for 10 cycles, then 1 → mode 0→1 exactly once, on the cycle release filtering completes (release edge + 2 sync + 4 filter). Single mode_chg pulse; auto_en stays 0.
- Long press: key_n=0 for 40 cycles, then release → auto_en 0→1 while the key is still held; mode unchanged at release. Then mode toggles every 10 cycles with a mode_chg pulse each time. A second long press → auto_en=0 and toggling stops.
- Collision: with auto_en=1, time a short-press release so its filter completes on the auto_cnt=9 cycle → exactly one toggle, auto_cnt restarts at 0, next auto toggle 10 cycles later.
- Reset mid-operation: assert rstn=0 while in HELD with auto_en=1 → auto_en=0, mode=0 immediately. Key held through reset release → auto_en stays 0 until a new full long press.
